// File: rtl/uart_tx_pkg.sv
// ============================================================================
// Module : uart_tx_pkg
// Shared types and constants for the UART transmit frame controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int unsigned DEFAULT_DATA_W = 8;

endpackage

`default_nettype wire

// File: rtl/uart_tx_ctrl_parity_calc.sv
// ============================================================================
// Module : parity_calc
// Combinational even/odd parity of one data word; only built when the
// UART_TX_PARITY_EN macro is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

`ifdef UART_TX_PARITY_EN
module parity_calc
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic              type_i,
  output logic              parity_o
);

  assign parity_o = (type_i == PAR_ODD) ? ~^data_i : ^data_i;

endmodule
`endif

`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
// ============================================================================
// Module : uart_tx_ctrl
// UART frame sequencer: start, DATA_W data bits, optional parity, stop.
// Parity stage present only when UART_TX_PARITY_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] P_DATA,
  input  logic              Data_valid,
  input  logic              PAR_EN,
  input  logic              PAR_TYP,
  input  logic              ser_data,
  input  logic              ser_done,
  output logic              ser_data_valid,
  output logic              ser_en,
  output logic              TX_OUT,
  output logic              busy
);

  state_e state_q, state_d;
  logic   w_accept;
  logic   w_par_en;

  assign w_accept       = Data_valid & (state_q == IDLE);
  assign ser_data_valid = w_accept;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_en_d;
  logic parity_q, parity_d;
  logic w_parity;

  parity_calc #(
    .DATA_W   (DATA_W)
  ) u_parity_calc (
    .data_i   (P_DATA),
    .type_i   (PAR_TYP),
    .parity_o (w_parity)
  );

  // Flags and parity are frozen at acceptance so the frame ignores later input changes.
  always_comb begin
    par_en_d = par_en_q;
    parity_d = parity_q;
    if (w_accept) begin
      par_en_d = PAR_EN;
      parity_d = w_parity;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      par_en_q <= 1'b0;
      parity_q <= 1'b0;
    end else begin
      par_en_q <= par_en_d;
      parity_q <= parity_d;
    end
  end

  assign w_par_en = par_en_q;
`else
  logic unused_inputs;
  assign unused_inputs = ^{P_DATA, PAR_EN, PAR_TYP};
  assign w_par_en      = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    TX_OUT  = 1'b1;
    busy    = 1'b0;
    ser_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Data_valid) state_d = START;
      end
      START: begin
        TX_OUT  = 1'b0;
        busy    = 1'b1;
        state_d = DATA;
      end
      DATA: begin
        TX_OUT = ser_data;
        busy   = 1'b1;
        ser_en = 1'b1;
        if (ser_done) state_d = w_par_en ? PARITY : STOP;
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        TX_OUT  = parity_q;
        busy    = 1'b1;
        state_d = STOP;
      end
`endif
      STOP: begin
        busy    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
// ============================================================================
// Module : tb_uart_tx_ctrl
// Bench for uart_tx_ctrl with a behavioural serializer and a frame-queue model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_ctrl;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [W-1:0] P_DATA = '0;
  logic         Data_valid = 1'b0;
  logic         PAR_EN = 1'b0;
  logic         PAR_TYP = 1'b0;
  logic         ser_data, ser_done;
  logic         ser_data_valid, ser_en, TX_OUT, busy;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  uart_tx_ctrl #(.DATA_W(W)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .P_DATA         (P_DATA),
    .Data_valid     (Data_valid),
    .PAR_EN         (PAR_EN),
    .PAR_TYP        (PAR_TYP),
    .ser_data       (ser_data),
    .ser_done       (ser_done),
    .ser_data_valid (ser_data_valid),
    .ser_en         (ser_en),
    .TX_OUT         (TX_OUT),
    .busy           (busy)
  );

  // Serializer: loads on the strobe, presents LSB, shifts while enabled.
  logic [W-1:0] sh;
  int           scnt;
  always @(posedge CLK) begin
    if (RST) begin
      sh   <= '0;
      scnt <= 0;
    end else if (ser_data_valid) begin
      sh   <= P_DATA;
      scnt <= 0;
    end else if (ser_en) begin
      sh   <= sh >> 1;
      scnt <= scnt + 1;
    end
  end
  assign ser_data = sh[0];
  assign ser_done = ser_en && (scnt == W - 1);

  // Reference: queue of per-cycle expected {line, busy, shift-enable} for the frame in flight.
  typedef struct packed {
    logic tx;
    logic bsy;
    logic en;
  } exp_t;

  exp_t q[$];
  logic armed = 1'b0;

  always @(posedge CLK) begin
    if (RST) begin
      q.delete();
    end else if (q.size() > 0) begin
      void'(q.pop_front());
    end else if (Data_valid) begin
      q.push_back('{tx: 1'b0, bsy: 1'b1, en: 1'b0});
      for (int i = 0; i < W; i++) q.push_back('{tx: P_DATA[i], bsy: 1'b1, en: 1'b1});
`ifdef UART_TX_PARITY_EN
      if (PAR_EN) begin
        int ones;
        ones = $countones(P_DATA);
        q.push_back('{tx: (PAR_TYP ? (ones % 2 == 0) : (ones % 2 == 1)), bsy: 1'b1, en: 1'b0});
      end
`endif
      q.push_back('{tx: 1'b1, bsy: 1'b1, en: 1'b0});
    end
    armed <= 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (armed) begin
      if (q.size() > 0) begin
        chk("tx_out", {31'd0, TX_OUT}, {31'd0, q[0].tx});
        chk("busy", {31'd0, busy}, {31'd0, q[0].bsy});
        chk("ser_en", {31'd0, ser_en}, {31'd0, q[0].en});
        chk("ser_data_valid", {31'd0, ser_data_valid}, 32'd0);
      end else begin
        chk("tx_out_idle", {31'd0, TX_OUT}, 32'd1);
        chk("busy_idle", {31'd0, busy}, 32'd0);
        chk("ser_en_idle", {31'd0, ser_en}, 32'd0);
        chk("ser_data_valid_idle", {31'd0, ser_data_valid}, {31'd0, Data_valid});
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 30) begin
      cyc();
      k++;
    end
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  // Accept one byte, then capture line/busy for cycles 1..n (bit index = cycle).
  task automatic send_cap(input logic [W-1:0] d, input logic pe, input logic pt, input int n,
                          output logic [15:0] txv, output logic [15:0] bv);
    txv = '0;
    bv  = '0;
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Data_valid = 1'b1;
    cyc();
    Data_valid = 1'b0;
    P_DATA = W'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
    for (int i = 1; i <= n; i++) begin
      @(negedge CLK);
      txv[i] = TX_OUT;
      bv[i]  = busy;
      cyc();
    end
  endtask

  logic [15:0] t, b;
  int          sdv_seen;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(); cyc();
    RST = 1'b0;
    @(negedge CLK);
    chk("reset_tx", {31'd0, TX_OUT}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_ser_en", {31'd0, ser_en}, 32'd0);
    cyc();

    send_cap(8'hA5, 1'b0, 1'b0, 11, t, b);
    chk("a5_line", {22'd0, t[10:1]}, 32'b1101001010);
    chk("a5_busy", {21'd0, b[11:1]}, 32'b01111111111);

`ifdef UART_TX_PARITY_EN
    wait_idle();
    send_cap(8'hA5, 1'b1, 1'b0, 12, t, b);
    chk("a5_even_parity", {31'd0, t[10]}, 32'd0);
    chk("a5_even_stop", {30'd0, t[11], b[12]}, 32'b10);
    wait_idle();
    send_cap(8'hA5, 1'b1, 1'b1, 12, t, b);
    chk("a5_odd_parity", {31'd0, t[10]}, 32'd1);
    chk("a5_odd_stop", {30'd0, t[11], b[12]}, 32'b10);
`else
    wait_idle();
    send_cap(8'hA5, 1'b1, 1'b1, 11, t, b);
    chk("a5_noparity_line", {22'd0, t[10:1]}, 32'b1101001010);
    chk("a5_noparity_busy", {21'd0, b[11:1]}, 32'b01111111111);
`endif

    // Requests during the frame must not disturb it.
    wait_idle();
    t = '0; sdv_seen = 0;
    P_DATA = 8'h3C; PAR_EN = 1'b0; Data_valid = 1'b1;
    cyc();
    for (int c = 1; c <= 11; c++) begin
      Data_valid = (c == 3 || c == 8);
      P_DATA = Data_valid ? 8'hFF : 8'h3C;
      @(negedge CLK);
      t[c] = TX_OUT;
      if (c <= 10 && ser_data_valid) sdv_seen++;
      cyc();
    end
    Data_valid = 1'b0;
    chk("ignore_line", {22'd0, t[10:1]}, 32'b1001111000);
    chk("ignore_sdv", sdv_seen, 32'd0);

    // Back-to-back with the request held high.
    wait_idle();
    t = '0; b = '0;
    P_DATA = 8'h01; PAR_EN = 1'b0; Data_valid = 1'b1;
    cyc();
    P_DATA = 8'h80;
    for (int c = 1; c <= 13; c++) begin
      @(negedge CLK);
      t[c] = TX_OUT;
      b[c] = busy;
      cyc();
    end
    Data_valid = 1'b0;
    chk("b2b_busy_gap", {29'd0, b[12:10]}, 32'b101);
    chk("b2b_second_start", {31'd0, t[12]}, 32'd0);

    // Reset in the middle of the data phase.
    wait_idle();
    P_DATA = 8'h55; PAR_EN = 1'b0; Data_valid = 1'b1;
    cyc();
    Data_valid = 1'b0;
    for (int c = 1; c <= 4; c++) cyc();
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    @(negedge CLK);
    chk("midrst_tx", {31'd0, TX_OUT}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_ser_en", {31'd0, ser_en}, 32'd0);
    cyc();
    send_cap(8'h55, 1'b0, 1'b0, 11, t, b);
    chk("post_rst_55_line", {22'd0, t[10:1]}, 32'b1010101010);
    chk("post_rst_55_busy", {21'd0, b[11:1]}, 32'b01111111111);

    // Random traffic, including occasional resets.
    for (int c = 0; c < 600; c++) begin
      Data_valid = ($urandom_range(0, 3) == 0);
      P_DATA     = W'($urandom);
      PAR_EN     = 1'($urandom);
      PAR_TYP    = 1'($urandom);
      RST        = ($urandom_range(0, 96) == 0);
      cyc();
    end
    RST = 1'b0;
    Data_valid = 1'b0;
    wait_idle();
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
